// File: rtl/memory_access_unit.sv
// memory_access_unit
// Load/store sequencer that sits between the decode/ALU stage and a data RAM
// whose response latency is not fixed. It accepts one instruction at a time.
// ALU and ADR results are written back one cycle after they are accepted.
// LDR and STR run a request/acknowledge handshake with the RAM. If the RAM
// never acknowledges, a timeout ends the request and sets a fault flag that
// stays set until the next accepted start.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no transaction; start is accepted; ALU/ADR write-back issued
// ST_REQ  | RAM_req high; waiting for RAM_ack or the timeout to expire
// (other) | unused code; the FSM recovers to ST_IDLE
module memory_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [3:0]        op_code,
    input  logic [DATA_W-1:0] SR1,
    input  logic [DATA_W-1:0] SR2,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic              memory_enable,
    input  logic [DATA_W-1:0] RAM_out,
    input  logic              RAM_ack,
    output logic              RAM_req,
    output logic              RW,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] RAM_in,
    output logic [DATA_W-1:0] reg_data,
    output logic              reg_we,
    output logic              busy,
    output logic              fault
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter value held during the last cycle a request may wait.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_req;
    logic               r_rw;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_ram_in;
    logic [DATA_W-1:0]  r_reg_data;
    logic               r_reg_we;
    logic               r_busy;
    logic               r_fault;

    state_t             w_state_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               w_req_nx;
    logic               w_rw_nx;
    logic [ADDR_W-1:0]  w_addr_nx;
    logic [DATA_W-1:0]  w_ram_in_nx;
    logic [DATA_W-1:0]  w_reg_data_nx;
    logic               w_reg_we_nx;
    logic               w_busy_nx;
    logic               w_fault_nx;

    // Next-state and next-output decode. Every output is registered, so no
    // input reaches an output within the same cycle.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_req_nx      = r_req;
        w_rw_nx       = r_rw;
        w_addr_nx     = r_addr;
        w_ram_in_nx   = r_ram_in;
        w_reg_data_nx = r_reg_data;
        w_reg_we_nx   = 1'b0;
        w_busy_nx     = r_busy;
        w_fault_nx    = r_fault;

        case (r_state)
            ST_IDLE: begin
                w_req_nx  = 1'b0;
                w_busy_nx = 1'b0;
                w_cnt_nx  = '0;
                if (start) begin
                    w_fault_nx = 1'b0;
                    case (op_code)
                        OP_ADR: begin
                            w_reg_data_nx = ALU_result;
                            w_reg_we_nx   = 1'b1;
                        end
                        OP_LDR: begin
                            w_addr_nx  = SR1[ADDR_W-1:0];
                            w_rw_nx    = 1'b1;
                            w_req_nx   = 1'b1;
                            w_busy_nx  = 1'b1;
                            w_state_nx = ST_REQ;
                        end
                        OP_STR: begin
                            w_addr_nx   = SR1[ADDR_W-1:0];
                            w_ram_in_nx = SR2;
                            w_rw_nx     = 1'b0;
                            w_req_nx    = 1'b1;
                            w_busy_nx   = 1'b1;
                            w_state_nx  = ST_REQ;
                        end
                        default: begin
                            if (memory_enable) begin
                                w_reg_data_nx = ALU_result;
                                w_reg_we_nx   = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_REQ: begin
                // An acknowledge on the final timeout cycle still completes normally.
                if (RAM_ack) begin
                    w_req_nx   = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                    if (r_rw) begin
                        w_reg_data_nx = RAM_out;
                        w_reg_we_nx   = 1'b1;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_req_nx   = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_fault_nx = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_req_nx   = 1'b0;
                w_busy_nx  = 1'b0;
                w_cnt_nx   = '0;
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State register and timeout counter.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Registered RAM-side, write-back and status outputs.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_req      <= 1'b0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_ram_in   <= '0;
            r_reg_data <= '0;
            r_reg_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_req      <= w_req_nx;
            r_rw       <= w_rw_nx;
            r_addr     <= w_addr_nx;
            r_ram_in   <= w_ram_in_nx;
            r_reg_data <= w_reg_data_nx;
            r_reg_we   <= w_reg_we_nx;
            r_busy     <= w_busy_nx;
            r_fault    <= w_fault_nx;
        end
    end

    assign RAM_req     = r_req;
    assign RW          = r_rw;
    assign address_out = r_addr;
    assign RAM_in      = r_ram_in;
    assign reg_data    = r_reg_data;
    assign reg_we      = r_reg_we;
    assign busy        = r_busy;
    assign fault       = r_fault;

endmodule

// File: tb/tb_memory_access_unit.sv
// Testbench for memory_access_unit: directed scenarios followed by a randomized
// mix of operations. Expected results come from a small model of the
// architectural state (the last write-back value and the fault flag).
module tb_memory_access_unit;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int TO  = 4;

    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    logic          clk = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op_code = 4'd0;
    logic [DW-1:0] SR1 = '0;
    logic [DW-1:0] SR2 = '0;
    logic [DW-1:0] ALU_result = '0;
    logic          memory_enable = 1'b0;
    logic [DW-1:0] RAM_out = '0;
    logic          RAM_ack = 1'b0;
    logic          RAM_req;
    logic          RW;
    logic [AW-1:0] address_out;
    logic [DW-1:0] RAM_in;
    logic [DW-1:0] reg_data;
    logic          reg_we;
    logic          busy;
    logic          fault;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_data  = '0;
    logic          m_fault = 1'b0;

    memory_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .Reset(Reset), .start(start), .op_code(op_code),
        .SR1(SR1), .SR2(SR2), .ALU_result(ALU_result),
        .memory_enable(memory_enable), .RAM_out(RAM_out), .RAM_ack(RAM_ack),
        .RAM_req(RAM_req), .RW(RW), .address_out(address_out), .RAM_in(RAM_in),
        .reg_data(reg_data), .reg_we(reg_we), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({RAM_req, RW, busy, reg_we, fault} !== 5'b0 || address_out !== '0 ||
            RAM_in !== '0 || reg_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs req=%b rw=%b busy=%b we=%b fault=%b addr=%h ram_in=%h data=%h, want all 0",
                     RAM_req, RW, busy, reg_we, fault, address_out, RAM_in, reg_data);
        end
        Reset = 1'b0;
        m_data  = '0;
        m_fault = 1'b0;
        @(negedge clk);
    endtask

    // Non-memory instruction: write-back one cycle later when enabled, never busy.
    task automatic run_alu(input logic [3:0] op, input logic me, input logic [DW-1:0] alu);
        logic exp_we;
        start = 1'b1; op_code = op; memory_enable = me; ALU_result = alu;
        SR1 = $urandom; SR2 = $urandom;
        @(negedge clk);
        start = 1'b0;
        exp_we  = (op == OP_ADR) || me;
        m_fault = 1'b0;
        if (exp_we) m_data = alu;
        checks++;
        if (reg_we !== exp_we || reg_data !== m_data) begin
            errors++;
            $display("FAIL alu_wb op=%h me=%b we=%b data=%h, want we=%b data=%h",
                     op, me, reg_we, reg_data, exp_we, m_data);
        end
        checks++;
        if ({busy, RAM_req, fault} !== 3'b000) begin
            errors++;
            $display("FAIL alu_status busy=%b req=%b fault=%b, want 000", busy, RAM_req, fault);
        end
    endtask

    // Memory instruction. ack_at = REQ cycle index (0-based) on which the RAM
    // acknowledges; ack_at >= TO means the RAM never answers.
    task automatic run_mem(input logic is_load, input logic [DW-1:0] sr1, input logic [DW-1:0] sr2,
                           input int ack_at, input logic [DW-1:0] rdata, input logic inject);
        int  req_cycles;
        int  exp_cycles;
        logic done;
        start = 1'b1; op_code = is_load ? OP_LDR : OP_STR; SR1 = sr1; SR2 = sr2;
        memory_enable = $urandom_range(0, 1);
        @(negedge clk);
        start = 1'b0;
        m_fault = 1'b0;
        checks++;
        if ({RAM_req, busy, RW} !== {2'b11, is_load} || address_out !== sr1[AW-1:0] ||
            (!is_load && RAM_in !== sr2)) begin
            errors++;
            $display("FAIL mem_issue req=%b busy=%b rw=%b addr=%h ram_in=%h, want 11%b addr=%h ram_in=%h",
                     RAM_req, busy, RW, address_out, RAM_in, is_load, sr1[AW-1:0], sr2);
        end
        req_cycles = 0;
        while (RAM_req === 1'b1 && req_cycles < TO + 3) begin
            checks++;
            if (reg_we !== 1'b0 || address_out !== sr1[AW-1:0] || RW !== is_load ||
                (!is_load && RAM_in !== sr2)) begin
                errors++;
                $display("FAIL mem_hold cyc=%0d we=%b addr=%h rw=%b ram_in=%h, want we=0 addr=%h",
                         req_cycles, reg_we, address_out, RW, RAM_in, sr1[AW-1:0]);
            end
            if (inject && req_cycles == 0) begin
                start = 1'b1; op_code = OP_STR; SR1 = ~sr1; SR2 = ~sr2;
            end else begin
                start = 1'b0;
            end
            if (req_cycles == ack_at) begin
                RAM_ack = 1'b1; RAM_out = rdata;
            end
            req_cycles++;
            @(negedge clk);
            RAM_ack = 1'b0;
            RAM_out = $urandom;
            start   = 1'b0;
        end
        done       = (ack_at < TO);
        exp_cycles = done ? ack_at + 1 : TO;
        checks++;
        if (req_cycles !== exp_cycles) begin
            errors++;
            $display("FAIL mem_req_len got=%0d cycles, want %0d", req_cycles, exp_cycles);
        end
        if (done && is_load) m_data = rdata;
        if (!done) m_fault = 1'b1;
        checks++;
        if (reg_we !== (done && is_load) || reg_data !== m_data || fault !== m_fault || busy !== 1'b0) begin
            errors++;
            $display("FAIL mem_done we=%b data=%h fault=%b busy=%b, want we=%b data=%h fault=%b busy=0",
                     reg_we, reg_data, fault, busy, done && is_load, m_data, m_fault);
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        checks++;
        if (reg_we !== 1'b0 || reg_data !== m_data || busy !== 1'b0 || fault !== m_fault) begin
            errors++;
            $display("FAIL %s we=%b data=%h busy=%b fault=%b, want we=0 data=%h busy=0 fault=%b",
                     tag, reg_we, reg_data, busy, fault, m_data, m_fault);
        end
    endtask

    task automatic test_alu();
        run_alu(4'b0000, 1'b1, 32'h0000_00A5);
        idle_check("alu_we_one_cycle");
        run_alu(4'b0011, 1'b0, 32'h1111_2222);
        run_alu(OP_ADR, 1'b0, 32'h0000_0ADD);
    endtask

    task automatic test_ldr();
        run_mem(1'b1, 32'h0000_0040, 32'h0, 2, 32'hDEAD_BEEF, 1'b0);
        idle_check("ldr_we_one_cycle");
    endtask

    task automatic test_back_to_back();
        run_mem(1'b0, 32'h0000_0044, 32'h0000_1234, 0, 32'hFFFF_FFFF, 1'b0);
        run_alu(OP_ADR, 1'b0, 32'h0000_5A5A);
    endtask

    task automatic test_timeout();
        run_mem(1'b1, 32'h0000_0080, 32'h0, 99, 32'h0BAD_0BAD, 1'b0);
        idle_check("timeout_fault_sticky");
        run_alu(4'b0001, 1'b0, 32'h0);
        run_mem(1'b1, 32'h0000_0084, 32'h0, TO - 1, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_start_during_req();
        run_mem(1'b0, 32'h0000_0100, 32'hABCD_0001, 2, 32'h0, 1'b1);
        idle_check("inject_ignored");
    endtask

    task automatic test_reset_mid_req();
        logic [DW-1:0] junk;
        start = 1'b1; op_code = OP_LDR; SR1 = 32'h0000_0200;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        #1;
        checks++;
        if ({RAM_req, RW, busy, reg_we, fault} !== 5'b0 || address_out !== '0 ||
            RAM_in !== '0 || reg_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_req req=%b rw=%b busy=%b we=%b fault=%b addr=%h data=%h, want all 0",
                     RAM_req, RW, busy, reg_we, fault, address_out, reg_data);
        end
        @(negedge clk);
        Reset = 1'b0;
        m_data = '0; m_fault = 1'b0;
        junk = $urandom;
        RAM_ack = 1'b1; RAM_out = junk;
        @(negedge clk);
        RAM_ack = 1'b0;
        checks++;
        if (reg_we !== 1'b0 || reg_data !== '0 || busy !== 1'b0 || RAM_req !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL late_ack_ignored we=%b data=%h busy=%b req=%b fault=%b, want all 0",
                     reg_we, reg_data, busy, RAM_req, fault);
        end
    endtask

    task automatic test_random();
        int sel;
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                op = 4'($urandom_range(0, 12));
                if (op == 4'd12) op = 4'd15;
                run_alu(op, 1'($urandom_range(0, 1)), $urandom);
            end else if (sel == 1) begin
                run_alu(OP_ADR, 1'($urandom_range(0, 1)), $urandom);
            end else begin
                run_mem(sel == 2, $urandom, $urandom, $urandom_range(0, TO + 1), $urandom,
                        1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 2) == 0) begin
                RAM_ack = 1'b1; RAM_out = $urandom;
                idle_check("idle_ack_ignored");
                RAM_ack = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_ldr();
        test_back_to_back();
        test_timeout();
        test_start_during_req();
        test_reset_mid_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Sequential load/store controller between the CPU decode/ALU stage and data RAM. It is the multi-cycle, parametrised successor of the combinational memory control path. It latches one instruction at a time, runs a request/acknowledge transaction with a RAM of arbitrary latency, and produces a registered write-back with a one-cycle write strobe. A missing RAM response is bounded by a timeout that raises a sticky fault.

## Interface

Parameters:
- DATA_W, 32, data, register and RAM word width
- ADDR_W, 32, RAM address width; address taken from SR1[ADDR_W-1:0] (ADDR_W ≤ DATA_W)
- TIMEOUT, 15, maximum cycles RAM_req stays high awaiting RAM_ack; legal range ≥ 1

Ports:
- clk  in  1  single clock, all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- start  in  1  instruction valid; sampled only when busy=0
- op_code  in  4  1100 ADR, 1101 LDR, 1110 STR, other = ALU
- SR1  in  DATA_W  base address operand
- SR2  in  DATA_W  store data
- ALU_result  in  DATA_W  ALU output for write-back
- memory_enable  in  1  ALU-class write-back enable
- RAM_out  in  DATA_W  RAM read data, valid with RAM_ack
- RAM_ack  in  1  RAM transaction complete
- RAM_req  out  1  RAM transaction request, level
- RW  out  1  1 = read, 0 = write
- address_out  out  ADDR_W  registered RAM address
- RAM_in  out  DATA_W  registered store data
- reg_data  out  DATA_W  registered write-back value
- reg_we  out  1  one-cycle write-back strobe
- busy  out  1  transaction in progress
- fault  out  1  sticky timeout flag

## Operation

- States: IDLE, REQ. A 2-bit encoding is allowed; the third code returns to IDLE.
- IDLE, start=1, op-dependent behaviour:
  - ALU with memory_enable=1: reg_data←ALU_result, reg_we=1 next cycle.
  - ALU with memory_enable=0: no action; reg_data holds.
  - ADR: reg_data←ALU_result, reg_we=1 next cycle, regardless of memory_enable.
  - LDR: address_out←SR1, RW←1, RAM_req←1, go to REQ.
  - STR: address_out←SR1, RAM_in←SR2, RW←0, RAM_req←1, go to REQ.
  - Any accepted start clears fault.
- REQ: busy=1. RAM_req, RW, address_out and RAM_in are held stable. The timeout counter (width clog2(TIMEOUT+1)) starts at 0.
  - RAM_ack=1: RAM_req←0, go to IDLE. LDR also loads reg_data←RAM_out and pulses reg_we. STR performs no write-back.
  - RAM_ack=0 and counter=TIMEOUT-1: RAM_req←0, fault←1, no write-back, go to IDLE.
  - Otherwise the counter increments.
  - If RAM_ack arrives on the final timeout cycle, ack wins.
- RAM_ack while in IDLE is ignored.
- start while busy=1 is ignored and not queued; the issuing stage must stall on busy.
- reg_we is never high for more than one consecutive cycle per instruction.
- Reset outputs: RAM_req=0, RW=0, address_out=0, RAM_in=0, reg_data=0, reg_we=0, busy=0, fault=0, state IDLE, counter 0.
- Reset asserted mid-REQ aborts the transaction immediately (asynchronously). No write-back occurs and fault is not set.

## Timing

- start sampled at edge N:
  - ALU/ADR: reg_we=1 during cycle N..N+1; busy stays 0; a new start is accepted at edge N+1.
  - LDR/STR: RAM_req=1 and busy=1 from edge N.
- RAM_ack sampled at edge M (M ≥ N+1):
  - RAM_req=0 and busy=0 after edge M.
  - LDR: reg_data valid and reg_we=1 for cycle M..M+1.
  - Next start accepted at edge M+1.
- Best-case load/store latency: 2 edges from start to completion (ack on the first REQ cycle).
- Timeout: RAM_req is high for at most TIMEOUT cycles. fault rises at edge N+TIMEOUT.
- Outputs are registered only, with no combinational path from inputs to outputs.

## Test plan

- Reset, then ALU start with ALU_result=0x0000_00A5, memory_enable=1 -> reg_data=0xA5 and reg_we=1 for exactly one cycle; busy never asserts. Repeat with memory_enable=0 -> reg_we=0, reg_data stays 0xA5.
- LDR with SR1=0x40, RAM acks 3 cycles after request with RAM_out=0xDEAD_BEEF -> RAM_req high 3 cycles, RW=1, address_out=0x40; then reg_data=0xDEADBEEF with a one-cycle reg_we; busy low the cycle after ack.
- STR with SR1=0x44, SR2=0x1234 and immediate ack -> RAM_in=0x1234, RW=0, RAM_req one cycle, reg_we never asserts; a back-to-back ADR start at edge M+1 is accepted.
- LDR with RAM_ack never asserted, TIMEOUT=4 -> RAM_req high exactly 4 cycles, then fault=1 and no reg_we. Next ALU start clears fault. Separately, ack on the 4th cycle -> normal completion with fault=0.
- start pulsed during REQ with op=STR -> ignored; address_out and RAM_in unchanged; only the original transaction completes.
- Reset asserted 2 cycles into an LDR -> RAM_req, busy and all outputs go to 0 immediately; a later ack does nothing; fault=0.
